// File: rtl/decode_queue_if.sv
// Fetch / register-file / hazard / Issue signals of the decode queue.
// master is the decode queue itself; slave is the surrounding pipeline.
interface decode_queue_if #(
    parameter int XLEN = 32,
    parameter int CW   = 3
);
    logic            if_id_valid;
    logic            if_id_ready;
    logic [31:0]     if_id_instruc;
    logic [XLEN-1:0] if_id_pc;
    logic            id_if_redirect;
    logic [XLEN-1:0] id_if_target;
    logic [4:0]      id_reg_addra;
    logic [4:0]      id_reg_addrb;
    logic [XLEN-1:0] reg_id_ass_dataa;
    logic [XLEN-1:0] reg_id_ass_datab;
    logic            id_hd_check_a;
    logic            id_hd_check_b;
    logic            hd_id_stall;
    logic            id_iss_valid;
    logic            iss_id_ready;
    logic [6:0]      id_iss_op;
    logic [2:0]      id_iss_funct3;
    logic [6:0]      id_iss_funct7;
    logic [4:0]      id_iss_rd;
    logic [4:0]      id_iss_addra;
    logic [4:0]      id_iss_addrb;
    logic [XLEN-1:0] id_iss_imedext;
    logic [XLEN-1:0] id_iss_pc;
    logic            id_iss_writereg;
    logic            id_iss_readmem;
    logic            id_iss_writemem;
    logic            id_iss_illegal;
    logic [CW-1:0]   id_count;

    modport master (
        input  if_id_valid, if_id_instruc, if_id_pc, reg_id_ass_dataa, reg_id_ass_datab,
               hd_id_stall, iss_id_ready,
        output if_id_ready, id_if_redirect, id_if_target, id_reg_addra, id_reg_addrb,
               id_hd_check_a, id_hd_check_b, id_iss_valid, id_iss_op, id_iss_funct3,
               id_iss_funct7, id_iss_rd, id_iss_addra, id_iss_addrb, id_iss_imedext,
               id_iss_pc, id_iss_writereg, id_iss_readmem, id_iss_writemem,
               id_iss_illegal, id_count
    );

    modport slave (
        output if_id_valid, if_id_instruc, if_id_pc, reg_id_ass_dataa, reg_id_ass_datab,
               hd_id_stall, iss_id_ready,
        input  if_id_ready, id_if_redirect, id_if_target, id_reg_addra, id_reg_addrb,
               id_hd_check_a, id_hd_check_b, id_iss_valid, id_iss_op, id_iss_funct3,
               id_iss_funct7, id_iss_rd, id_iss_addra, id_iss_addrb, id_iss_imedext,
               id_iss_pc, id_iss_writereg, id_iss_readmem, id_iss_writemem,
               id_iss_illegal, id_count
    );
endinterface

// File: rtl/decode_queue.sv
// RV32I decode queue: DEPTH-entry fetch buffer, head decode with branch/jump
// resolution, and a registered valid/ready bundle towards Issue.
module decode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic           clock,
    input  logic           reset,
    decode_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [6:0]      op;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rd;
        logic [4:0]      addra;
        logic [4:0]      addrb;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            writereg;
        logic            readmem;
        logic            writemem;
        logic            illegal;
    } bundle_t;

    logic [31:0]     q_instr [DEPTH];
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;

    logic            head_valid, push, pop, taken, br_cond;
    logic            is_jal, is_jalr, is_branch, rd_write;
    logic [31:0]     h_instr;
    logic [6:0]      h_op;
    logic [XLEN-1:0] h_pc, jalr_sum, tgt_next;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    bundle_t         dec, out_q;
    logic            out_vld, redirect;
    logic [XLEN-1:0] target;

    assign head_valid = (count != '0);
    assign h_instr    = q_instr[rd_ptr];
    assign h_pc       = q_pc[rd_ptr];
    assign h_op       = h_instr[6:0];

    assign bus.if_id_ready = (count < CW'(DEPTH)) && !redirect;
    assign push = bus.if_id_valid && bus.if_id_ready;
    assign pop  = head_valid && !bus.hd_id_stall && (!out_vld || bus.iss_id_ready);

    assign bus.id_reg_addra  = h_instr[19:15];
    assign bus.id_reg_addrb  = h_instr[24:20];
    assign bus.id_hd_check_a = head_valid && !(h_op == OP_LUI || h_op == OP_AUIPC || h_op == OP_JAL);
    assign bus.id_hd_check_b = head_valid && (h_op == OP_BRANCH || h_op == OP_STORE || h_op == OP_REG);

    assign imm_i = XLEN'($signed(h_instr[31:20]));
    assign imm_s = XLEN'($signed({h_instr[31:25], h_instr[11:7]}));
    assign imm_b = XLEN'($signed({h_instr[31], h_instr[7], h_instr[30:25], h_instr[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({h_instr[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({h_instr[31], h_instr[19:12], h_instr[20], h_instr[30:21], 1'b0}));

    always_comb begin
        dec        = '0;
        dec.op     = h_op;
        dec.funct3 = h_instr[14:12];
        dec.funct7 = h_instr[31:25];
        dec.rd     = h_instr[11:7];
        dec.addra  = h_instr[19:15];
        dec.addrb  = h_instr[24:20];
        dec.pc     = h_pc;
        rd_write   = 1'b0;
        is_jal     = 1'b0;
        is_jalr    = 1'b0;
        is_branch  = 1'b0;
        case (h_op)
            OP_LUI, OP_AUIPC: begin dec.imm = imm_u; rd_write = 1'b1; end
            OP_JAL:           begin dec.imm = imm_j; rd_write = 1'b1; is_jal = 1'b1; end
            OP_JALR:          begin dec.imm = imm_i; rd_write = 1'b1; is_jalr = 1'b1; end
            OP_BRANCH: begin
                dec.imm     = imm_b;
                is_branch   = 1'b1;
                // funct3 010/011 have no branch meaning
                dec.illegal = (h_instr[14:13] == 2'b01);
            end
            OP_LOAD:             begin dec.imm = imm_i; rd_write = 1'b1; dec.readmem = 1'b1; end
            OP_STORE:            begin dec.imm = imm_s; dec.writemem = 1'b1; end
            OP_IMM:              begin dec.imm = imm_i; rd_write = 1'b1; end
            OP_REG:              rd_write = 1'b1;
            OP_FENCE, OP_SYSTEM: dec.imm = imm_i;
            default:             dec.illegal = 1'b1;
        endcase
        dec.writereg = rd_write && (h_instr[11:7] != 5'd0);
    end

    always_comb begin
        br_cond = 1'b0;
        case (h_instr[14:12])
            3'b000:  br_cond = (bus.reg_id_ass_dataa == bus.reg_id_ass_datab);
            3'b001:  br_cond = (bus.reg_id_ass_dataa != bus.reg_id_ass_datab);
            3'b100:  br_cond = ($signed(bus.reg_id_ass_dataa) <  $signed(bus.reg_id_ass_datab));
            3'b101:  br_cond = ($signed(bus.reg_id_ass_dataa) >= $signed(bus.reg_id_ass_datab));
            3'b110:  br_cond = (bus.reg_id_ass_dataa <  bus.reg_id_ass_datab);
            3'b111:  br_cond = (bus.reg_id_ass_dataa >= bus.reg_id_ass_datab);
            default: br_cond = 1'b0;
        endcase
    end

    assign taken    = pop && (is_jal || is_jalr || (is_branch && br_cond));
    assign jalr_sum = bus.reg_id_ass_dataa + dec.imm;
    assign tgt_next = is_jalr ? (jalr_sum & {{(XLEN-1){1'b1}}, 1'b0}) : (h_pc + dec.imm);

    // A taken control transfer empties the queue, including any same-cycle push.
    always_ff @(posedge clock) begin
        if (reset || taken) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push && !taken) begin
            q_instr[wr_ptr] <= bus.if_id_instruc;
            q_pc[wr_ptr]    <= bus.if_id_pc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q    <= '0;
            out_vld  <= 1'b0;
            redirect <= 1'b0;
            target   <= '0;
        end else begin
            if (pop) begin
                out_q   <= dec;
                out_vld <= 1'b1;
            end else if (out_vld && bus.iss_id_ready) begin
                out_vld <= 1'b0;
            end
            redirect <= taken;
            if (taken) target <= tgt_next;
        end
    end

    assign bus.id_if_redirect  = redirect;
    assign bus.id_if_target    = target;
    assign bus.id_count        = count;
    assign bus.id_iss_valid    = out_vld;
    assign bus.id_iss_op       = out_q.op;
    assign bus.id_iss_funct3   = out_q.funct3;
    assign bus.id_iss_funct7   = out_q.funct7;
    assign bus.id_iss_rd       = out_q.rd;
    assign bus.id_iss_addra    = out_q.addra;
    assign bus.id_iss_addrb    = out_q.addrb;
    assign bus.id_iss_imedext  = out_q.imm;
    assign bus.id_iss_pc       = out_q.pc;
    assign bus.id_iss_writereg = out_q.writereg;
    assign bus.id_iss_readmem  = out_q.readmem;
    assign bus.id_iss_writemem = out_q.writemem;
    assign bus.id_iss_illegal  = out_q.illegal;
endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed scenarios plus randomized traffic against
// a queue-based reference model of the decode stage.
module tb_decode_queue;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [6:0] op; logic [2:0] f3; logic [6:0] f7;
    logic [4:0] rd, ra, rb;
    logic [31:0] imm, pc;
    logic wr, rm, wm, ill;
  } bundle_t;
  typedef struct packed { logic [31:0] instr; logic [31:0] pc; } ent_t;

  logic clock = 1'b0;
  logic reset;
  decode_queue_if #(.XLEN(32), .CW(3)) bus();

  decode_queue #(.XLEN(32), .DEPTH(DEPTH)) dut (.clock(clock), .reset(reset), .bus(bus.master));

  always #5 clock = ~clock;

  bundle_t dut_b;
  assign dut_b = {bus.id_iss_op, bus.id_iss_funct3, bus.id_iss_funct7, bus.id_iss_rd,
                  bus.id_iss_addra, bus.id_iss_addrb, bus.id_iss_imedext, bus.id_iss_pc,
                  bus.id_iss_writereg, bus.id_iss_readmem, bus.id_iss_writemem, bus.id_iss_illegal};

  int checks, failures;
  ent_t mq[$];
  bundle_t m_out;
  logic m_vld, m_redir;
  logic [31:0] m_tgt;

  function automatic logic [31:0] sx(input logic [31:0] v, input int w);
    return 32'($signed(v << (32 - w)) >>> (32 - w));
  endfunction

  function automatic void ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                     input logic [31:0] a, input logic [31:0] b,
                                     output bundle_t o, output logic tk, output logic [31:0] tg);
    logic wr;
    o = '0; tk = 1'b0; tg = '0; wr = 1'b0;
    o.op = ins[6:0]; o.f3 = ins[14:12]; o.f7 = ins[31:25];
    o.rd = ins[11:7]; o.ra = ins[19:15]; o.rb = ins[24:20]; o.pc = pc;
    case (ins[6:0])
      7'h37, 7'h17: begin o.imm = ins & 32'hFFFF_F000; wr = 1'b1; end
      7'h6F: begin
        o.imm = sx({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
        wr = 1'b1; tk = 1'b1; tg = pc + o.imm;
      end
      7'h67: begin o.imm = sx(ins >> 20, 12); wr = 1'b1; tk = 1'b1; tg = (a + o.imm) & 32'hFFFF_FFFE; end
      7'h63: begin
        o.imm = sx({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
        tg = pc + o.imm;
        case (ins[14:12])
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = (a >= b);
          default: o.ill = 1'b1;
        endcase
      end
      7'h03: begin o.imm = sx(ins >> 20, 12); wr = 1'b1; o.rm = 1'b1; end
      7'h23: begin o.imm = sx({ins[31:25], ins[11:7]}, 12); o.wm = 1'b1; end
      7'h13: begin o.imm = sx(ins >> 20, 12); wr = 1'b1; end
      7'h33: wr = 1'b1;
      7'h0F, 7'h73: o.imm = sx(ins >> 20, 12);
      default: o.ill = 1'b1;
    endcase
    o.wr = wr && (o.rd != 5'd0);
  endfunction

  // Advance model and DUT across one rising edge using the currently driven inputs.
  task automatic tick();
    ent_t h; bundle_t b; logic tk, rdy, push, pop; logic [31:0] tg;
    tk = 1'b0;
    rdy  = (mq.size() < DEPTH) && !m_redir;
    push = bus.if_id_valid && rdy;
    pop  = (mq.size() != 0) && !bus.hd_id_stall && (!m_vld || bus.iss_id_ready);
    if (reset) begin
      mq.delete(); m_out = '0; m_vld = 1'b0; m_redir = 1'b0; m_tgt = '0;
    end else begin
      if (pop) begin
        h = mq.pop_front();
        ref_decode(h.instr, h.pc, bus.reg_id_ass_dataa, bus.reg_id_ass_datab, b, tk, tg);
        m_out = b; m_vld = 1'b1;
      end else if (m_vld && bus.iss_id_ready) m_vld = 1'b0;
      if (tk) begin mq.delete(); m_tgt = tg; end
      else if (push) mq.push_back({bus.if_id_instruc, bus.if_id_pc});
      m_redir = tk;
    end
    @(posedge clock); #1;
  endtask

  task automatic idle();
    bus.if_id_valid = 0; bus.if_id_instruc = '0; bus.if_id_pc = '0;
    bus.iss_id_ready = 1; bus.hd_id_stall = 0;
    bus.reg_id_ass_dataa = '0; bus.reg_id_ass_datab = '0;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    bus.if_id_valid = v; bus.if_id_instruc = ins; bus.if_id_pc = pc;
  endtask

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'h13};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [12];
    logic [31:0] w;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h0B};
    w = $urandom();
    w[6:0] = ops[$urandom_range(0, 11)];
    return w;
  endfunction

  task automatic test_reset();
    idle(); bus.iss_id_ready = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, addi(5'($urandom_range(1, 31)), 5'd0, 12'($urandom())), 32'h40 + 32'(4 * i)); tick();
    end
    drive(0, '0, '0); #1;
    checks++; if (bus.id_count !== 3'd3) begin failures++; $display("FAIL pre_rst_count got=%0d exp=3", bus.id_count); end
    checks++; if (bus.id_iss_valid !== 1'b1) begin failures++; $display("FAIL pre_rst_valid got=%b exp=1", bus.id_iss_valid); end
    reset = 1; bus.if_id_valid = 1; tick(); reset = 0; bus.if_id_valid = 0; #1;
    checks++; if (bus.id_count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", bus.id_count); end
    checks++; if (bus.id_iss_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.id_iss_valid); end
    checks++; if (bus.id_if_redirect !== 1'b0 || bus.id_if_target !== 32'h0) begin failures++; $display("FAIL rst_redirect got=%b/%h exp=0/0", bus.id_if_redirect, bus.id_if_target); end
    checks++; if (dut_b !== '0) begin failures++; $display("FAIL rst_bundle got=%h exp=0", dut_b); end
    checks++; if (bus.id_hd_check_a !== 1'b0 || bus.id_hd_check_b !== 1'b0) begin failures++; $display("FAIL rst_checks got=%b%b exp=00", bus.id_hd_check_a, bus.id_hd_check_b); end
  endtask

  task automatic test_stream();
    idle();
    drive(1, 32'h0050_0093, 32'h0); tick();
    drive(1, 32'h0011_2423, 32'h4); tick();
    drive(0, '0, '0); #1;
    checks++; if (bus.id_iss_valid !== 1 || bus.id_iss_imedext !== 32'd5 || bus.id_iss_writereg !== 1 || bus.id_iss_pc !== 32'h0)
      begin failures++; $display("FAIL addi_bundle got v=%b imm=%h wr=%b pc=%h exp 1/5/1/0", bus.id_iss_valid, bus.id_iss_imedext, bus.id_iss_writereg, bus.id_iss_pc); end
    checks++; if (bus.id_hd_check_b !== 1 || bus.id_reg_addrb !== 5'd1 || bus.id_reg_addra !== 5'd2)
      begin failures++; $display("FAIL sw_head got chkb=%b rb=%0d ra=%0d exp 1/1/2", bus.id_hd_check_b, bus.id_reg_addrb, bus.id_reg_addra); end
    tick();
    checks++; if (bus.id_iss_valid !== 1 || bus.id_iss_imedext !== 32'd8 || bus.id_iss_writemem !== 1 || bus.id_iss_writereg !== 0 || bus.id_iss_pc !== 32'h4)
      begin failures++; $display("FAIL sw_bundle got v=%b imm=%h wm=%b wr=%b pc=%h exp 1/8/1/0/4", bus.id_iss_valid, bus.id_iss_imedext, bus.id_iss_writemem, bus.id_iss_writereg, bus.id_iss_pc); end
    tick();
    checks++; if (bus.id_iss_valid !== 0) begin failures++; $display("FAIL stream_drain_valid got=%b exp=0", bus.id_iss_valid); end
  endtask

  task automatic test_backpressure();
    idle(); bus.iss_id_ready = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1, addi(5'($urandom_range(1, 31)), 5'($urandom()), 12'($urandom())), 32'h200 + 32'(4 * i)); tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, rand_instr(), 32'h300); #1;
      checks++; if (bus.id_count !== 3'd4 || bus.if_id_ready !== 0) begin failures++; $display("FAIL full got count=%0d rdy=%b exp 4/0", bus.id_count, bus.if_id_ready); end
      checks++; if (bus.id_iss_valid !== 1 || dut_b !== m_out || bus.id_iss_pc !== 32'h200) begin failures++; $display("FAIL hold got v=%b %h exp 1 %h", bus.id_iss_valid, dut_b, m_out); end
      tick();
    end
    drive(0, '0, '0); bus.iss_id_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++; if (bus.id_iss_pc !== 32'h200 + 32'(4 * k) || bus.id_count !== 3'(4 - k) || dut_b !== m_out)
        begin failures++; $display("FAIL drain%0d got pc=%h count=%0d exp pc=%h count=%0d", k, bus.id_iss_pc, bus.id_count, 32'h200 + 32'(4 * k), 4 - k); end
    end
    tick();
    checks++; if (bus.id_iss_valid !== 0) begin failures++; $display("FAIL drain_end_valid got=%b exp=0", bus.id_iss_valid); end
  endtask

  task automatic fill_branch();
    idle(); bus.hd_id_stall = 1;
    drive(1, 32'hFE20_8CE3, 32'h100); tick();
    drive(1, addi(5'd3, 5'd0, 12'($urandom())), 32'h104); tick();
    drive(1, addi(5'd4, 5'd0, 12'($urandom())), 32'h108); tick();
    drive(1, addi(5'd5, 5'd0, 12'($urandom())), 32'h10C);
    bus.hd_id_stall = 0; bus.reg_id_ass_dataa = 32'd7;
  endtask

  task automatic test_branch();
    fill_branch(); bus.reg_id_ass_datab = 32'd7; tick();
    drive(1, addi(5'd6, 5'd0, 12'd1), 32'h110); #1;
    checks++; if (bus.id_if_redirect !== 1 || bus.id_if_target !== 32'hF8) begin failures++; $display("FAIL beq_redirect got %b/%h exp 1/f8", bus.id_if_redirect, bus.id_if_target); end
    checks++; if (bus.id_count !== 3'd0 || bus.if_id_ready !== 0) begin failures++; $display("FAIL beq_flush got count=%0d rdy=%b exp 0/0", bus.id_count, bus.if_id_ready); end
    checks++; if (bus.id_iss_valid !== 1 || bus.id_iss_op !== 7'h63 || bus.id_iss_pc !== 32'h100) begin failures++; $display("FAIL beq_dispatch got v=%b op=%h pc=%h exp 1/63/100", bus.id_iss_valid, bus.id_iss_op, bus.id_iss_pc); end
    tick(); drive(0, '0, '0); #1;
    checks++; if (bus.id_if_redirect !== 0 || bus.id_count !== 3'd0 || bus.id_iss_valid !== 0) begin failures++; $display("FAIL beq_after got redir=%b count=%0d v=%b exp 0/0/0", bus.id_if_redirect, bus.id_count, bus.id_iss_valid); end
    fill_branch(); bus.reg_id_ass_datab = 32'd8; tick(); drive(0, '0, '0); #1;
    checks++; if (bus.id_if_redirect !== 0 || bus.id_count !== 3'd3 || bus.id_iss_pc !== 32'h100) begin failures++; $display("FAIL bne_path got redir=%b count=%0d pc=%h exp 0/3/100", bus.id_if_redirect, bus.id_count, bus.id_iss_pc); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if (bus.id_iss_pc !== 32'h100 + 32'(4 * k) || dut_b !== m_out) begin failures++; $display("FAIL young%0d got pc=%h exp %h", k, bus.id_iss_pc, 32'h100 + 32'(4 * k)); end
    end
  endtask

  task automatic test_jalr();
    idle(); bus.reg_id_ass_dataa = 32'h1000;
    drive(1, 32'h0031_80E7, 32'h300); tick(); drive(0, '0, '0); tick();
    checks++; if (bus.id_if_redirect !== 1 || bus.id_if_target !== 32'h1002) begin failures++; $display("FAIL jalr_target got %b/%h exp 1/1002", bus.id_if_redirect, bus.id_if_target); end
    checks++; if (bus.id_iss_writereg !== 1 || bus.id_iss_rd !== 5'd1 || bus.id_iss_imedext !== 32'd3) begin failures++; $display("FAIL jalr_bundle got wr=%b rd=%0d imm=%h exp 1/1/3", bus.id_iss_writereg, bus.id_iss_rd, bus.id_iss_imedext); end
    tick();
    drive(1, 32'h0010_0013, 32'h304); tick(); drive(0, '0, '0); tick();
    checks++; if (bus.id_iss_valid !== 1 || bus.id_iss_writereg !== 0 || bus.id_iss_imedext !== 32'd1) begin failures++; $display("FAIL addi_x0 got v=%b wr=%b imm=%h exp 1/0/1", bus.id_iss_valid, bus.id_iss_writereg, bus.id_iss_imedext); end
  endtask

  task automatic test_stall();
    idle();
    drive(1, addi(5'd1, 5'd0, 12'd9), 32'h400); tick();
    drive(1, addi(5'd2, 5'd7, 12'd9), 32'h404); tick();
    bus.hd_id_stall = 1;
    for (int i = 0; i < 3; i++) begin drive(1, addi(5'd3, 5'd0, 12'($urandom())), 32'h408 + 32'(4 * i)); tick(); end
    drive(1, addi(5'd4, 5'd0, 12'd0), 32'h500); #1;
    checks++; if (bus.id_iss_valid !== 0 || bus.id_count !== 3'd4 || bus.if_id_ready !== 0) begin failures++; $display("FAIL stall got v=%b count=%0d rdy=%b exp 0/4/0", bus.id_iss_valid, bus.id_count, bus.if_id_ready); end
    checks++; if (bus.id_reg_addra !== 5'd7) begin failures++; $display("FAIL stall_head got ra=%0d exp 7", bus.id_reg_addra); end
    tick(); drive(0, '0, '0); bus.hd_id_stall = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (bus.id_iss_pc !== 32'h404 + 32'(4 * k) || dut_b !== m_out) begin failures++; $display("FAIL unstall%0d got pc=%h exp %h", k, bus.id_iss_pc, 32'h404 + 32'(4 * k)); end
    end
    bus.reg_id_ass_dataa = 32'd5; bus.reg_id_ass_datab = 32'd5;
    drive(1, 32'h0010_A063, 32'h600); tick(); drive(0, '0, '0); tick();
    checks++; if (bus.id_iss_illegal !== 1 || bus.id_if_redirect !== 0 || bus.id_iss_writereg !== 0) begin failures++; $display("FAIL br_illegal got ill=%b redir=%b wr=%b exp 1/0/0", bus.id_iss_illegal, bus.id_if_redirect, bus.id_iss_writereg); end
    tick();
    checks++; if (bus.id_if_redirect !== 0) begin failures++; $display("FAIL br_illegal_late got redir=%b exp 0", bus.id_if_redirect); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom() & 32'hFFFF_FFFC);
      bus.iss_id_ready = $urandom_range(0, 3) != 0;
      bus.hd_id_stall = $urandom_range(0, 4) == 0;
      bus.reg_id_ass_dataa = $urandom_range(0, 3);
      bus.reg_id_ass_datab = $urandom_range(0, 3);
      reset = ($urandom_range(0, 99) == 0);
      #1;
      checks++; if (bus.if_id_ready !== ((mq.size() < DEPTH) && !m_redir)) begin failures++; $display("FAIL rnd_ready c=%0d got=%b", c, bus.if_id_ready); end
      checks++; if (bus.id_count !== 3'(mq.size())) begin failures++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, bus.id_count, mq.size()); end
      checks++; if (bus.id_iss_valid !== m_vld) begin failures++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, bus.id_iss_valid, m_vld); end
      checks++; if (dut_b !== m_out) begin failures++; $display("FAIL rnd_bundle c=%0d got=%h exp=%h", c, dut_b, m_out); end
      checks++; if (bus.id_if_redirect !== m_redir || bus.id_if_target !== m_tgt) begin failures++; $display("FAIL rnd_redirect c=%0d got=%b/%h exp=%b/%h", c, bus.id_if_redirect, bus.id_if_target, m_redir, m_tgt); end
      if (mq.size() != 0) begin
        checks++; if (bus.id_hd_check_a !== !(mq[0].instr[6:0] inside {7'h37, 7'h17, 7'h6F}) || bus.id_hd_check_b !== (mq[0].instr[6:0] inside {7'h63, 7'h23, 7'h33}))
          begin failures++; $display("FAIL rnd_checks c=%0d got=%b%b instr=%h", c, bus.id_hd_check_a, bus.id_hd_check_b, mq[0].instr); end
        checks++; if (bus.id_reg_addra !== mq[0].instr[19:15] || bus.id_reg_addrb !== mq[0].instr[24:20])
          begin failures++; $display("FAIL rnd_regaddr c=%0d got=%0d/%0d instr=%h", c, bus.id_reg_addra, bus.id_reg_addrb, mq[0].instr); end
      end else begin
        checks++; if (bus.id_hd_check_a !== 0 || bus.id_hd_check_b !== 0) begin failures++; $display("FAIL rnd_empty_checks c=%0d got=%b%b exp=00", c, bus.id_hd_check_a, bus.id_hd_check_b); end
      end
      tick();
    end
    reset = 0;
  endtask

  initial begin
    checks = 0; failures = 0;
    mq.delete(); m_out = '0; m_vld = 0; m_redir = 0; m_tgt = '0;
    reset = 1; idle();
    tick(); tick();
    reset = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_branch();
    test_jalr();
    test_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised successor decode stage for the RV32I pipeline.
- Sits between Fetch and Issue and buffers fetched instructions in a DEPTH-entry queue.
- Decodes the head entry with full RV32I immediate generation (I/S/B/U/J) and resolves branches and jumps at the head.
- Presents a registered, valid/ready-handshaked decoded bundle to Issue. A taken branch flushes the queue and issues a one-cycle redirect.

Parameters:
- XLEN, 32, data and PC width.
- DEPTH, 4, queue entries (power of two, ≥2).
- CW, $clog2(DEPTH+1), width of occupancy count.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- if_id_valid  in  1  fetch offers an instruction
- if_id_ready  out  1  queue accepts the instruction
- if_id_instruc  in  32  instruction word
- if_id_pc  in  XLEN  PC of the instruction
- id_if_redirect  out  1  one-cycle redirect pulse to fetch
- id_if_target  out  XLEN  redirect target
- id_reg_addra  out  5  head rs1, async to register file
- id_reg_addrb  out  5  head rs2, async to register file
- reg_id_ass_dataa  in  XLEN  rs1 data (async)
- reg_id_ass_datab  in  XLEN  rs2 data (async)
- id_hd_check_a  out  1  head actually reads rs1
- id_hd_check_b  out  1  head actually reads rs2
- hd_id_stall  in  1  hazard unit blocks the head
- id_iss_valid  out  1  decoded bundle valid
- iss_id_ready  in  1  Issue accepts the bundle
- id_iss_op  out  7  opcode
- id_iss_funct3  out  3  funct3
- id_iss_funct7  out  7  funct7
- id_iss_rd  out  5  destination register
- id_iss_addra  out  5  rs1
- id_iss_addrb  out  5  rs2
- id_iss_imedext  out  XLEN  sign-extended immediate
- id_iss_pc  out  XLEN  instruction PC
- id_iss_writereg  out  1  writes rd (forced 0 when rd=x0)
- id_iss_readmem  out  1  load
- id_iss_writemem  out  1  store
- id_iss_illegal  out  1  unrecognised opcode or branch funct3
- id_count  out  CW  queue occupancy

Behaviour:
- Reset (synchronous, active-high; dominates all other events):
  - Queue empty, id_count=0.
  - id_iss_valid=0, id_if_redirect=0, id_if_target=0.
  - All id_iss_* fields 0.
- Queue is a circular FIFO of {instruc, pc} with wrapping read/write pointers.
- if_id_ready = (id_count < DEPTH) && !id_if_redirect. No bypass when full.
- push = if_id_valid && if_id_ready.
- pop = head valid && !hd_id_stall && (!id_iss_valid || iss_id_ready).
- Push and pop in the same cycle leave id_count unchanged; pointers both advance.
- id_reg_addra/addrb, id_hd_check_a/b and the head decode are combinational from the head entry. When the queue is empty, check_a and check_b are 0.
- Operand checks:
  - check_a = 0 only for LUI, AUIPC and JAL.
  - check_b = 1 only for BRANCH, STORE and OP (R-type).
- Immediates:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - All sign-extended to XLEN. R-type immediate is 0.
- Branch comparison at pop, using register data:
  - funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
  - funct3 010/011 raise illegal and are never taken.
- Targets:
  - JAL and branches: pc+imm.
  - JALR: (rs1+imm) & ~1.
  - Arithmetic is modulo 2^XLEN.
- Output register: on pop, load the head bundle and set id_iss_valid=1.
  - If valid && ready && !pop, clear id_iss_valid.
  - While valid && !ready, all id_iss_* hold stable.
- Taken branch, JAL or JALR on pop:
  - At that edge, every other queue entry is discarded and any same-cycle push is dropped.
  - id_count becomes 0.
  - The branch/jump itself is dispatched; JAL/JALR write rd.
  - Next cycle: id_if_redirect=1 with id_if_target, for exactly one cycle. if_id_ready=0 during that cycle.
- Latency: an instruction pushed at edge k appears on id_iss_valid after edge k+1 at the earliest. Throughput is 1 per cycle.
- Illegal instructions are dispatched with writereg/readmem/writemem = 0 and illegal = 1. They never redirect.

Test Plan:
- Reset with queue holding 3 entries and id_iss_valid=1 -> next cycle id_count=0, id_iss_valid=0, id_if_redirect=0.
- Stream ADDI x1,x0,5 (pc 0x0) and SW x1,8(x2) (pc 0x4), iss_id_ready=1 -> ADDI bundle after the 2nd edge with imm=5, writereg=1; SW next cycle with imm=8, writemem=1, check_b=1.
- iss_id_ready=0 while pushing 5 instructions, DEPTH=4 -> 1 held in the output register, 4 queued; if_id_ready=0 at id_count=4; outputs stable. Release ready -> in-order drain, count 4→0.
- BEQ x1,x2,-8 at pc 0x100 with dataa=datab=7 and 2 younger entries queued -> queue flushed, redirect=1 one cycle with target 0xF8, push that cycle ignored. Repeat with datab=8 -> no redirect, younger entries dispatched.
- JALR x1,x3,3 with dataa=0x1000 -> target 0x1002, writereg=1, rd=1. ADDI x0,x0,1 -> writereg=0.
- hd_id_stall=1 for 3 cycles on the head -> no pop, id_iss_valid falls after handshake, pushes continue until full. Branch funct3=010 -> illegal=1, no redirect.
